// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sequencer
// Description : Layer-level control FSM for the convolution datapath. One
//               accepted `start` runs a complete layer: an outer loop over
//               output-channel groups (oc) and an inner loop over input-channel
//               groups (ic), streaming N pixels per inner pass. The block
//               drives the datapath's feature-map/weight/bias read addresses,
//               its valid/reset strobes and its static settings. It counts
//               returned results to generate output write addresses.
//
// Optional    : `define SEQ_DRAIN_TIMEOUT_EN adds a DRAIN watchdog (parameter
//               TIMEOUT) and a sticky `seq_timeout` output. Without the macro
//               the port does not exist and DRAIN waits indefinitely.
//
// Ports       :
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle layer start request (ignored unless IDLE)
//   cfg_fm_len           pixels per channel-group pass (N)
//   cfg_ic_groups        input-channel groups (I)
//   cfg_oc_groups        output-channel groups (O)
//   cfg_row_len          line-buffer length
//   cfg_scale            requantisation shift
//   cfg_pw_mode          pointwise mode
//   cfg_rd_base          input feature-map base address
//   cfg_wr_base          output feature-map base address
//   Conv_data_valid_out  datapath result strobe
//   state_rst            datapath abort request (forces IDLE)
//   Conv_data_valid_in   pixel issue strobe
//   adder_rst            accumulator clear (one cycle per oc group)
//   bias_out_valid       bias-add enable on the final ic pass
//   Conv_scale_in        latched scale
//   buff_len_ctrl        latched row length
//   buff_len_rst         line-buffer reset
//   PW_mode              latched mode
//   fm_rd_addr           input read address
//   fm_wr_addr           output write address
//   fm_DDR_wr            write strobe for fm_wr_addr
//   wm_addr_rd           weight read address
//   bm_addr_rd           bias read address
//   current_state        FSM state code (IDLE=0 PREP=1 STREAM=2 DRAIN=3 DONE=4)
//   busy                 FSM not in IDLE
//   seq_timeout          sticky DRAIN watchdog flag (optional)
//   done                 one-cycle completion pulse
//   cfg_err              one-cycle bad-configuration pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
  parameter int FM_AW = 13,
  parameter int WM_AW = 8,
  parameter int BM_AW = 9,
  parameter int BUF_W = 9
`ifdef SEQ_DRAIN_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [FM_AW-1:0] cfg_fm_len,
  input  logic [3:0]       cfg_ic_groups,
  input  logic [4:0]       cfg_oc_groups,
  input  logic [BUF_W-1:0] cfg_row_len,
  input  logic [3:0]       cfg_scale,
  input  logic             cfg_pw_mode,
  input  logic [FM_AW-1:0] cfg_rd_base,
  input  logic [FM_AW-1:0] cfg_wr_base,
  input  logic             Conv_data_valid_out,
  input  logic             state_rst,
  output logic             Conv_data_valid_in,
  output logic             adder_rst,
  output logic             bias_out_valid,
  output logic [3:0]       Conv_scale_in,
  output logic [BUF_W-1:0] buff_len_ctrl,
  output logic             buff_len_rst,
  output logic             PW_mode,
  output logic [FM_AW-1:0] fm_rd_addr,
  output logic [FM_AW-1:0] fm_wr_addr,
  output logic             fm_DDR_wr,
  output logic [WM_AW-1:0] wm_addr_rd,
  output logic [BM_AW-1:0] bm_addr_rd,
  output logic [2:0]       current_state,
  output logic             busy,
`ifdef SEQ_DRAIN_TIMEOUT_EN
  output logic             seq_timeout,
`endif
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;

  // Latched layer configuration
  logic [FM_AW-1:0] r_n;
  logic [3:0]       r_ic_groups;
  logic [4:0]       r_oc_groups;
  logic [FM_AW-1:0] r_rd_base;
  logic [FM_AW-1:0] r_wr_base;

  // Loop state
  logic [4:0]       r_oc;
  logic [3:0]       r_ic;
  logic [FM_AW-1:0] r_pix;
  logic [FM_AW-1:0] r_out_cnt;
  // ic*N + pix is a plain linear count within an oc group, so the read
  // offset is kept as a running counter rather than a multiply.
  logic [FM_AW-1:0] r_rd_off;
  // Running oc*N and oc*I products, bumped once per oc group.
  logic [FM_AW-1:0] r_oc_n;
  logic [WM_AW-1:0] r_wm_base;

`ifdef SEQ_DRAIN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
`endif

  logic       w_pix_last;
  logic       w_ic_last;
  logic       w_oc_last;
  logic [3:0] w_ic_nxt;
  logic       w_cnt_ok;
  logic       w_cfg_bad;

  assign w_pix_last = (r_pix == r_n - FM_AW'(1));
  assign w_ic_last  = (r_ic == r_ic_groups - 4'd1);
  assign w_oc_last  = (r_oc == r_oc_groups - 5'd1);
  assign w_ic_nxt   = r_ic + 4'd1;
  // A result is accepted only while the group still expects results.
  assign w_cnt_ok   = Conv_data_valid_out && (r_state != S_IDLE) && (r_out_cnt < r_n);
  assign w_cfg_bad  = (cfg_fm_len == '0) || (cfg_ic_groups == 4'd0) || (cfg_oc_groups == 5'd0);

  assign current_state = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state            <= S_IDLE;
      r_n                <= '0;
      r_ic_groups        <= '0;
      r_oc_groups        <= '0;
      r_rd_base          <= '0;
      r_wr_base          <= '0;
      r_oc               <= '0;
      r_ic               <= '0;
      r_pix              <= '0;
      r_out_cnt          <= '0;
      r_rd_off           <= '0;
      r_oc_n             <= '0;
      r_wm_base          <= '0;
      Conv_data_valid_in <= 1'b0;
      adder_rst          <= 1'b0;
      bias_out_valid     <= 1'b0;
      Conv_scale_in      <= '0;
      buff_len_ctrl      <= '0;
      buff_len_rst       <= 1'b0;
      PW_mode            <= 1'b0;
      fm_rd_addr         <= '0;
      fm_wr_addr         <= '0;
      fm_DDR_wr          <= 1'b0;
      wm_addr_rd         <= '0;
      bm_addr_rd         <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      cfg_err            <= 1'b0;
`ifdef SEQ_DRAIN_TIMEOUT_EN
      r_tmo              <= '0;
      seq_timeout        <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes default low
      adder_rst    <= 1'b0;
      buff_len_rst <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      fm_DDR_wr    <= 1'b0;

      if (state_rst) begin
        // Abort wins over everything; latched configuration is kept.
        r_state            <= S_IDLE;
        busy               <= 1'b0;
        Conv_data_valid_in <= 1'b0;
        bias_out_valid     <= 1'b0;
      end else begin
        // Result counting runs in every non-IDLE state, independent of
        // the loop position; the address/strobe lag the valid by a cycle.
        if (w_cnt_ok) begin
          fm_DDR_wr  <= 1'b1;
          fm_wr_addr <= r_wr_base + r_oc_n + r_out_cnt;
          r_out_cnt  <= r_out_cnt + FM_AW'(1);
        end

        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_cfg_bad) begin
                cfg_err <= 1'b1;
              end else begin
                r_n           <= cfg_fm_len;
                r_ic_groups   <= cfg_ic_groups;
                r_oc_groups   <= cfg_oc_groups;
                r_rd_base     <= cfg_rd_base;
                r_wr_base     <= cfg_wr_base;
                Conv_scale_in <= cfg_scale;
                buff_len_ctrl <= cfg_row_len;
                PW_mode       <= cfg_pw_mode;
                r_oc          <= '0;
                r_oc_n        <= '0;
                r_wm_base     <= '0;
                r_ic          <= '0;
                r_pix         <= '0;
                r_out_cnt     <= '0;
                adder_rst     <= 1'b1;
                buff_len_rst  <= 1'b1;
                busy          <= 1'b1;
                r_state       <= S_PREP;
`ifdef SEQ_DRAIN_TIMEOUT_EN
                seq_timeout   <= 1'b0;
`endif
              end
            end
          end

          S_PREP: begin
            // Set up the first pixel of the first ic pass.
            r_ic               <= '0;
            r_pix              <= '0;
            r_rd_off           <= '0;
            Conv_data_valid_in <= 1'b1;
            fm_rd_addr         <= r_rd_base;
            wm_addr_rd         <= r_wm_base;
            bm_addr_rd         <= BM_AW'(r_oc);
            bias_out_valid     <= (r_ic_groups == 4'd1);
            r_state            <= S_STREAM;
          end

          S_STREAM: begin
            if (w_pix_last && w_ic_last) begin
              Conv_data_valid_in <= 1'b0;
              bias_out_valid     <= 1'b0;
              r_state            <= S_DRAIN;
`ifdef SEQ_DRAIN_TIMEOUT_EN
              r_tmo              <= '0;
`endif
            end else begin
              r_rd_off   <= r_rd_off + FM_AW'(1);
              fm_rd_addr <= r_rd_base + r_rd_off + FM_AW'(1);
              if (w_pix_last) begin
                // Next ic pass: accumulation continues, no adder_rst.
                r_pix          <= '0;
                r_ic           <= w_ic_nxt;
                wm_addr_rd     <= r_wm_base + WM_AW'(w_ic_nxt);
                bias_out_valid <= (w_ic_nxt == r_ic_groups - 4'd1);
              end else begin
                r_pix <= r_pix + FM_AW'(1);
              end
            end
          end

          S_DRAIN: begin
            // Uses the registered count, so a strobe that completes the
            // group is counted here and the move happens next cycle.
            if (r_out_cnt == r_n) begin
              if (w_oc_last) begin
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_oc         <= r_oc + 5'd1;
                r_oc_n       <= r_oc_n + r_n;
                r_wm_base    <= r_wm_base + WM_AW'(r_ic_groups);
                r_out_cnt    <= '0;
                adder_rst    <= 1'b1;
                buff_len_rst <= 1'b1;
                r_state      <= S_PREP;
              end
            end
`ifdef SEQ_DRAIN_TIMEOUT_EN
            else if (w_cnt_ok) begin
              r_tmo <= '0;
            end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
              seq_timeout <= 1'b1;
              busy        <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
`endif
          end

          S_DONE: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end

          default: begin
            // Unused codes recover to IDLE.
            busy               <= 1'b0;
            Conv_data_valid_in <= 1'b0;
            bias_out_valid     <= 1'b0;
            r_state            <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_layer_sequencer
// Description : Directed self-checking bench for conv_layer_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [12:0] cfg_fm_len;
  logic [3:0]  cfg_ic_groups;
  logic [4:0]  cfg_oc_groups;
  logic [8:0]  cfg_row_len;
  logic [3:0]  cfg_scale;
  logic        cfg_pw_mode;
  logic [12:0] cfg_rd_base;
  logic [12:0] cfg_wr_base;
  logic        Conv_data_valid_out;
  logic        state_rst;
  logic        Conv_data_valid_in;
  logic        adder_rst;
  logic        bias_out_valid;
  logic [3:0]  Conv_scale_in;
  logic [8:0]  buff_len_ctrl;
  logic        buff_len_rst;
  logic        PW_mode;
  logic [12:0] fm_rd_addr;
  logic [12:0] fm_wr_addr;
  logic        fm_DDR_wr;
  logic [7:0]  wm_addr_rd;
  logic [8:0]  bm_addr_rd;
  logic [2:0]  current_state;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_arst  = 0;
  int n_done  = 0;
  int n_wr    = 0;
  int base_arst;
  int base_done;
  int base_wr;

  conv_layer_sequencer dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .cfg_fm_len          (cfg_fm_len),
    .cfg_ic_groups       (cfg_ic_groups),
    .cfg_oc_groups       (cfg_oc_groups),
    .cfg_row_len         (cfg_row_len),
    .cfg_scale           (cfg_scale),
    .cfg_pw_mode         (cfg_pw_mode),
    .cfg_rd_base         (cfg_rd_base),
    .cfg_wr_base         (cfg_wr_base),
    .Conv_data_valid_out (Conv_data_valid_out),
    .state_rst           (state_rst),
    .Conv_data_valid_in  (Conv_data_valid_in),
    .adder_rst           (adder_rst),
    .bias_out_valid      (bias_out_valid),
    .Conv_scale_in       (Conv_scale_in),
    .buff_len_ctrl       (buff_len_ctrl),
    .buff_len_rst        (buff_len_rst),
    .PW_mode             (PW_mode),
    .fm_rd_addr          (fm_rd_addr),
    .fm_wr_addr          (fm_wr_addr),
    .fm_DDR_wr           (fm_DDR_wr),
    .wm_addr_rd          (wm_addr_rd),
    .bm_addr_rd          (bm_addr_rd),
    .current_state       (current_state),
    .busy                (busy),
    .done                (done),
    .cfg_err             (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (adder_rst) n_arst++;
    if (done)      n_done++;
    if (fm_DDR_wr) n_wr++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [12:0] n, input logic [3:0] ic, input logic [4:0] oc,
                         input logic [12:0] rdb, input logic [12:0] wrb, input logic [3:0] sc);
    cfg_fm_len    = n;
    cfg_ic_groups = ic;
    cfg_oc_groups = oc;
    cfg_rd_base   = rdb;
    cfg_wr_base   = wrb;
    cfg_scale     = sc;
  endtask

  // Deliver n result strobes and check each registered write
  task automatic feed(input int n, input logic [12:0] base);
    logic [12:0] exp_addr;
    for (int i = 0; i < n; i++) begin
      Conv_data_valid_out = 1'b1;
      tick();
      exp_addr = base + 13'(i);
      chk("wr_strobe", {31'd0, fm_DDR_wr}, 32'd1);
      chk("wr_addr", {19'd0, fm_wr_addr}, {19'd0, exp_addr});
    end
    Conv_data_valid_out = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    Conv_data_valid_out = 1'b0;
    state_rst = 1'b0;
    cfg_row_len = 9'd0;
    cfg_pw_mode = 1'b0;
    set_cfg(13'd0, 4'd0, 5'd0, 13'd0, 13'd0, 4'd0);

    // ---------------- reset state ----------------
    tick(2);
    chk("rst_state", {29'd0, current_state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid_in", {31'd0, Conv_data_valid_in}, 32'd0);
    chk("rst_rd_addr", {19'd0, fm_rd_addr}, 32'd0);
    chk("rst_scale", {28'd0, Conv_scale_in}, 32'd0);
    rstn = 1'b1;
    tick();

    // ---------------- A: N=4 I=2 O=1 rd_base=0x100 ----------------
    base_arst = n_arst;
    base_done = n_done;
    set_cfg(13'd4, 4'd2, 5'd1, 13'h100, 13'h000, 4'd5);
    cfg_row_len = 9'd33;
    cfg_pw_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("A_prep_state", {29'd0, current_state}, 32'd1);
    chk("A_prep_adder_rst", {31'd0, adder_rst}, 32'd1);
    chk("A_prep_buf_rst", {31'd0, buff_len_rst}, 32'd1);
    chk("A_busy", {31'd0, busy}, 32'd1);
    chk("A_scale", {28'd0, Conv_scale_in}, 32'd5);
    chk("A_row_len", {23'd0, buff_len_ctrl}, 32'd33);
    chk("A_pw", {31'd0, PW_mode}, 32'd1);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("A_valid_in", {31'd0, Conv_data_valid_in}, 32'd1);
      chk("A_rd_addr", {19'd0, fm_rd_addr}, 32'h100 + 32'(k));
      chk("A_wm_addr", {24'd0, wm_addr_rd}, (k < 4) ? 32'd0 : 32'd1);
      chk("A_bias_valid", {31'd0, bias_out_valid}, (k < 4) ? 32'd0 : 32'd1);
      tick();
    end
    chk("A_drain_state", {29'd0, current_state}, 32'd3);
    chk("A_drain_valid_in", {31'd0, Conv_data_valid_in}, 32'd0);
    feed(4, 13'h000);
    tick();
    chk("A_done_state", {29'd0, current_state}, 32'd4);
    chk("A_done_pulse", {31'd0, done}, 32'd1);
    tick();
    chk("A_idle_state", {29'd0, current_state}, 32'd0);
    chk("A_idle_busy", {31'd0, busy}, 32'd0);
    chk("A_adder_rst_count", 32'(n_arst - base_arst), 32'd1);
    chk("A_done_count", 32'(n_done - base_done), 32'd1);

    // ---------------- B: N=3 I=1 O=2 wr_base=0x200 ----------------
    base_arst = n_arst;
    base_done = n_done;
    set_cfg(13'd3, 4'd1, 5'd2, 13'h000, 13'h200, 4'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("B_bias_valid", {31'd0, bias_out_valid}, 32'd1);
    tick(3);
    chk("B_drain0", {29'd0, current_state}, 32'd3);
    feed(3, 13'h200);
    tick();
    chk("B_prep1_state", {29'd0, current_state}, 32'd1);
    chk("B_prep1_adder_rst", {31'd0, adder_rst}, 32'd1);
    tick();
    chk("B_oc1_bm", {23'd0, bm_addr_rd}, 32'd1);
    chk("B_oc1_wm", {24'd0, wm_addr_rd}, 32'd1);
    chk("B_oc1_rd", {19'd0, fm_rd_addr}, 32'd0);
    tick(3);
    chk("B_drain1", {29'd0, current_state}, 32'd3);
    feed(3, 13'h203);
    tick();
    chk("B_wr_idle_low", {31'd0, fm_DDR_wr}, 32'd0);
    chk("B_done_state", {29'd0, current_state}, 32'd4);
    tick();
    chk("B_done_count", 32'(n_done - base_done), 32'd1);
    chk("B_adder_rst_count", 32'(n_arst - base_arst), 32'd2);

    // ---------------- C: 5 strobes with N=3 ----------------
    base_wr = n_wr;
    base_done = n_done;
    set_cfg(13'd3, 4'd1, 5'd1, 13'h000, 13'h000, 4'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    Conv_data_valid_out = 1'b1;
    tick(5);
    Conv_data_valid_out = 1'b0;
    tick(3);
    chk("C_wr_count", 32'(n_wr - base_wr), 32'd3);
    chk("C_done_count", 32'(n_done - base_done), 32'd1);
    chk("C_idle", {29'd0, current_state}, 32'd0);

    // ---------------- D: bad config, start while busy, abort ----------------
    set_cfg(13'd4, 4'd0, 5'd1, 13'h000, 13'h000, 4'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("D_cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("D_err_busy", {31'd0, busy}, 32'd0);
    chk("D_err_state", {29'd0, current_state}, 32'd0);
    tick();
    chk("D_cfg_err_clear", {31'd0, cfg_err}, 32'd0);

    base_done = n_done;
    set_cfg(13'd2, 4'd1, 5'd1, 13'h010, 13'h000, 4'd3);
    start = 1'b1;
    tick();
    set_cfg(13'd7, 4'd3, 5'd3, 13'h500, 13'h000, 4'd9);
    tick();
    start = 1'b0;
    chk("D_busy_state", {29'd0, current_state}, 32'd2);
    chk("D_busy_scale", {28'd0, Conv_scale_in}, 32'd3);
    chk("D_busy_rd0", {19'd0, fm_rd_addr}, 32'h010);
    tick();
    chk("D_busy_rd1", {19'd0, fm_rd_addr}, 32'h011);
    tick();
    chk("D_drain", {29'd0, current_state}, 32'd3);
    state_rst = 1'b1;
    tick();
    state_rst = 1'b0;
    chk("D_abort_state", {29'd0, current_state}, 32'd0);
    chk("D_abort_busy", {31'd0, busy}, 32'd0);
    tick(3);
    chk("D_abort_no_done", 32'(n_done - base_done), 32'd0);
    chk("D_abort_scale_kept", {28'd0, Conv_scale_in}, 32'd3);

    // ---------------- E: async reset mid-STREAM, then wrap-around run ----------------
    set_cfg(13'd8, 4'd1, 5'd1, 13'h000, 13'h000, 4'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    chk("E_streaming", {29'd0, current_state}, 32'd2);
    #3;
    rstn = 1'b0;
    #1;
    chk("E_async_state", {29'd0, current_state}, 32'd0);
    chk("E_async_valid_in", {31'd0, Conv_data_valid_in}, 32'd0);
    chk("E_async_busy", {31'd0, busy}, 32'd0);
    chk("E_async_scale", {28'd0, Conv_scale_in}, 32'd0);
    #2;
    rstn = 1'b1;
    tick();

    base_done = n_done;
    set_cfg(13'd2, 4'd1, 5'd1, 13'h1FFF, 13'h1FFF, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("E_no_early_valid", {31'd0, Conv_data_valid_in}, 32'd0);
    tick();
    chk("E_latency_valid", {31'd0, Conv_data_valid_in}, 32'd1);
    chk("E_rd_top", {19'd0, fm_rd_addr}, 32'h1FFF);
    tick();
    chk("E_rd_wrap", {19'd0, fm_rd_addr}, 32'h0000);
    tick();
    feed(2, 13'h1FFF);
    tick(2);
    chk("E_done_count", 32'(n_done - base_done), 32'd1);
    chk("E_final_idle", {29'd0, current_state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Layer-level control FSM sitting directly upstream of the convolution datapath top.
- Generates that datapath's control-path inputs: feature-map, weight and bias addresses; valid/reset strobes; the scale, buffer-length and mode settings; and the 3-bit `current_state`.
- Consumes `Conv_data_valid_out` to count results and to drive write addresses. Consumes `state_rst` as an abort.
- Runs one convolution layer per `start`: loops over output-channel groups (outer) and input-channel groups (inner).

Parameters:
- FM_AW, 13, feature-map address width
- WM_AW, 8, weight-memory read address width
- BM_AW, 9, bias-memory read address width
- BUF_W, 9, line-buffer length width
- TIMEOUT, 1023, drain watchdog limit in cycles (optional feature only)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle layer start request
- cfg_fm_len  in  FM_AW  pixels per channel-group pass (N)
- cfg_ic_groups  in  4  input-channel groups (I)
- cfg_oc_groups  in  5  output-channel groups (O)
- cfg_row_len  in  BUF_W  line-buffer length
- cfg_scale  in  4  requantisation shift
- cfg_pw_mode  in  1  pointwise mode
- cfg_rd_base  in  FM_AW  input FM base address
- cfg_wr_base  in  FM_AW  output FM base address
- Conv_data_valid_out  in  1  datapath result strobe
- state_rst  in  1  datapath abort request
- Conv_data_valid_in  out  1  pixel issue strobe
- adder_rst  out  1  accumulator clear
- bias_out_valid  out  1  bias-add enable for the final pass
- Conv_scale_in  out  4  latched scale
- buff_len_ctrl  out  BUF_W  latched row length
- buff_len_rst  out  1  line-buffer reset
- PW_mode  out  1  latched mode
- fm_rd_addr  out  FM_AW  input read address
- fm_wr_addr  out  FM_AW  output write address
- fm_DDR_wr  out  1  high when a result is written at `fm_wr_addr`
- wm_addr_rd  out  WM_AW  weight read address
- bm_addr_rd  out  BM_AW  bias read address
- current_state  out  3  FSM state code
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle bad-config pulse

Behaviour:
- Reset: every output is 0; the FSM is in IDLE. All outputs are registered.
- `current_state` encoding: IDLE=0, PREP=1, STREAM=2, DRAIN=3, DONE=4. Codes 5–7 are never produced; if reached, the FSM goes to IDLE next cycle.
- IDLE:
  - `start` with N=0, I=0 or O=0 gives a `cfg_err` pulse and the FSM stays in IDLE.
  - Otherwise all cfg_* are latched, oc=0 and the FSM goes to PREP.
  - `start` outside IDLE is ignored.
- PREP (exactly 1 cycle):
  - `adder_rst` and `buff_len_rst` are high for this cycle.
  - ic=0, pix=0, out_cnt=0.
  - Next state is STREAM.
- STREAM:
  - `Conv_data_valid_in` is high every cycle.
  - `fm_rd_addr` = rd_base + ic*N + pix, truncated mod 2^FM_AW (wraps silently).
  - `wm_addr_rd` = oc*I + ic, truncated to WM_AW.
  - `bm_addr_rd` = oc.
  - `bias_out_valid` = (ic == I-1).
  - pix increments each cycle. When pix reaches N-1:
    - if ic < I-1, then ic++ and pix=0, with no `adder_rst` (accumulation continues);
    - otherwise the next state is DRAIN.
- Output counting (any state except IDLE):
  - Each `Conv_data_valid_out` high while out_cnt < N:
    - `fm_DDR_wr` is high for one cycle;
    - `fm_wr_addr` = wr_base + oc*N + out_cnt, registered (write strobe and address appear 1 cycle after the valid);
    - out_cnt++.
  - Strobes arriving when out_cnt == N, or in IDLE, are dropped.
- DRAIN:
  - `Conv_data_valid_in` is 0.
  - Once out_cnt == N: if oc < O-1, oc++ and the next state is PREP; otherwise DONE.
  - If out_cnt reaches N in the same cycle a strobe arrives, that strobe is counted and the transition follows next cycle.
- DONE (1 cycle): `done`=1, then IDLE.
- Abort: `state_rst` high in any state forces IDLE next cycle and clears all strobes. It has priority over every other transition. Latched cfg values are retained.
- Constant outputs: `Conv_scale_in`, `buff_len_ctrl` and `PW_mode` hold their latched values until the next accepted `start`.
- Latency from `start` to the first `Conv_data_valid_in` is 2 cycles.

Optional Feature:
- Macro: SEQ_DRAIN_TIMEOUT_EN.
- Enabled:
  - a counter resets on entry to DRAIN and on every counted `Conv_data_valid_out`;
  - if it reaches TIMEOUT while in DRAIN, a sticky `seq_timeout` output is set and the FSM goes to IDLE without `done`;
  - `seq_timeout` clears on the next accepted `start`.
- Disabled: no `seq_timeout` port; DRAIN waits indefinitely.

Test Plan:
- Reset mid-STREAM (rstn low) → all outputs 0 asynchronously, `current_state`=0; a new `start` works normally.
- N=4, I=2, O=1, rd_base=0x100:
  - `fm_rd_addr` sequence is 0x100..0x107 on 8 consecutive cycles;
  - `wm_addr_rd` is 0,0,0,0,1,1,1,1;
  - `bias_out_valid` is high only on the last 4 cycles;
  - `adder_rst` fires once.
- N=3, I=1, O=2, wr_base=0x200, with 3 valids per group → `fm_wr_addr` 0x200,0x201,0x202 then 0x203,0x204,0x205; a single `done`; `adder_rst` fires twice.
- Inject 5 valid_out strobes with N=3 → only 3 `fm_DDR_wr` pulses; the extra strobes are ignored.
- `start` with I=0 → `cfg_err` pulse, `busy` stays 0. `start` while busy → ignored.
- `state_rst` asserted in DRAIN → IDLE next cycle, no `done`. With SEQ_DRAIN_TIMEOUT_EN and TIMEOUT=15, withholding valid_out → `seq_timeout`=1 after 15 DRAIN cycles.
